// File: rtl/calculate_layer3_pkg.sv
// Shared types and sizing helpers for the layer-3 window accumulator.
package calculate_layer3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Accumulator wide enough for TAPS unsigned products plus a signed bias.
  function automatic int acc_width(input int prod_width, input int taps);
    return prod_width + $clog2(taps) + 2;
  endfunction

  function automatic int cnt_width(input int taps);
    return ($clog2(taps + 1) < 1) ? 1 : $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/calculate_layer3_sat.sv
// Combinational arithmetic rescale and saturation to the signed output width.
// Optional CALCULATE_LAYER3_ACC_RELU_EN forces negative results to zero.
module calculate_layer3_sat #(
  parameter int ACC_WIDTH  = 89,
  parameter int FRAC_SHIFT = 36,
  parameter int OUT_WIDTH  = 32
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic signed [OUT_WIDTH-1:0] result,
  output logic                        sat
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] shifted;

  assign shifted = sum >>> FRAC_SHIFT;

  // Clamp to the representable range; only true clamps raise sat.
  always_comb begin
    result = shifted[OUT_WIDTH-1:0];
    sat    = 1'b0;
    if (shifted > MAX_V) begin
      result = MAX_V[OUT_WIDTH-1:0];
      sat    = 1'b1;
    end else if (shifted < MIN_V) begin
`ifdef CALCULATE_LAYER3_ACC_RELU_EN
      result = '0;
      sat    = 1'b0;
`else
      result = MIN_V[OUT_WIDTH-1:0];
      sat    = 1'b1;
`endif
    end else begin
`ifdef CALCULATE_LAYER3_ACC_RELU_EN
      result = shifted[ACC_WIDTH-1] ? '0 : shifted[OUT_WIDTH-1:0];
`else
      result = shifted[OUT_WIDTH-1:0];
`endif
      sat    = 1'b0;
    end
  end

endmodule

// File: rtl/calculate_layer3_acc.sv
// LeNet-5 layer-3 window accumulator: sums TAPS products plus bias, rescales, saturates.
// Build option CALCULATE_LAYER3_ACC_RELU_EN enables ReLU clamping of negative results.
module calculate_layer3_acc
  import calculate_layer3_pkg::*;
#(
  parameter int PROD_WIDTH = 79,
  parameter int TAPS       = 150,
  parameter int BIAS_WIDTH = 32,
  parameter int FRAC_SHIFT = 36,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [PROD_WIDTH-1:0]        prod_din,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic signed [OUT_WIDTH-1:0]  out_dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         sat_flag
);

  localparam int ACC_WIDTH = acc_width(PROD_WIDTH, TAPS);
  localparam int CNT_WIDTH = cnt_width(TAPS);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TAPS - 1);

  state_t                      state;
  state_t                      state_next;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        accept;
  logic                        last;
  logic signed [OUT_WIDTH-1:0] sat_result;
  logic                        sat_hit;

  assign bias_ext = ACC_WIDTH'(bias);
  assign prod_ext = ACC_WIDTH'(prod_din);
  assign accept   = prod_valid & prod_ready;
  // First product of a window starts from the bias instead of the running sum.
  assign sum      = ((state == IDLE) ? bias_ext : acc) + prod_ext;

  always_comb begin
    case (state)
      IDLE:    last = (TAPS == 1);
      ACCUM:   last = (cnt == LAST_CNT);
      default: last = 1'b0;
    endcase
  end

  calculate_layer3_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .sum   (sum),
    .result(sat_result),
    .sat   (sat_hit)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (TAPS == 1) ? RESULT : ACCUM;
        end else begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (accept && last) begin
          state_next = RESULT;
        end else begin
          state_next = ACCUM;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESULT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so no input-to-output paths.
  always_comb begin
    prod_ready = 1'b1;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        prod_ready = 1'b1;
        out_valid  = 1'b0;
        busy       = 1'b0;
      end
      ACCUM: begin
        prod_ready = 1'b1;
        out_valid  = 1'b0;
        busy       = 1'b1;
      end
      RESULT: begin
        prod_ready = 1'b0;
        out_valid  = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        prod_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      out_dout <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= (state == IDLE) ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
      if (last) begin
        out_dout <= sat_result;
        sat_flag <= sat_flag | sat_hit;
      end else begin
        out_dout <= out_dout;
        sat_flag <= sat_flag;
      end
    end else begin
      acc      <= acc;
      cnt      <= cnt;
      out_dout <= out_dout;
      sat_flag <= sat_flag;
    end
  end

endmodule

// File: tb/tb_calculate_layer3_acc.sv
// Self-checking bench for calculate_layer3_acc with TAPS=4, FRAC_SHIFT=4, OUT_WIDTH=8.
module tb_calculate_layer3_acc;

  localparam int PW   = 24;
  localparam int TAPS = 4;
  localparam int BW   = 16;
  localparam int FS   = 4;
  localparam int OW   = 8;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic [PW-1:0]        prod_din = '0;
  logic                 prod_valid = 1'b0;
  logic                 prod_ready;
  logic signed [BW-1:0] bias = '0;
  logic signed [OW-1:0] out_dout;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 busy;
  logic                 sat_flag;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  bit sat_model = 1'b0;

  calculate_layer3_acc #(
    .PROD_WIDTH(PW), .TAPS(TAPS), .BIAS_WIDTH(BW), .FRAC_SHIFT(FS), .OUT_WIDTH(OW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_din(prod_din), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .bias(bias),
    .out_dout(out_dout), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    if (out_valid && out_ready) hs_count <= hs_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum, arithmetic shift, clamp to the signed output range.
  function automatic void ref_window(input longint b, input longint q[$],
                                     output longint r, output bit s);
    longint total_sum;
    longint sh;
    total_sum = b;
    foreach (q[i]) total_sum += q[i];
    sh = total_sum >>> FS;
    s = 1'b0;
    if (sh > 127) begin
      r = 127; s = 1'b1;
    end else if (sh < -128) begin
`ifdef CALCULATE_LAYER3_ACC_RELU_EN
      r = 0;
`else
      r = -128; s = 1'b1;
`endif
    end else begin
      r = sh;
`ifdef CALCULATE_LAYER3_ACC_RELU_EN
      if (sh < 0) r = 0;
`endif
    end
  endfunction

  // Offer one product after `gap` idle cycles; returns just after the accepting edge.
  task automatic send(input longint p, input int gap);
    int n;
    prod_valid = 1'b0;
    repeat (gap) begin @(posedge ap_clk); #1; end
    n = 0;
    while (!prod_ready && n < 20) begin @(posedge ap_clk); #1; n++; end
    if (n >= 20) check("ready_timeout", 64'(prod_ready), 64'sd1);
    prod_din = PW'(p);
    prod_valid = 1'b1;
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
  endtask

  task automatic run_window(input string tag, input longint b, input longint q[$],
                            input int maxgap, input int hold);
    longint r;
    bit s;
    int hs0;
    bias = BW'(b);
    hs0 = hs_count;
    foreach (q[i]) send(q[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    ref_window(b, q, r, s);
    sat_model = sat_model | s;
    check({tag, "_valid"}, 64'(out_valid), 64'sd1);
    check({tag, "_dout"}, 64'(out_dout), r);
    check({tag, "_sat"}, 64'(sat_flag), 64'(sat_model));
    check({tag, "_ready_res"}, 64'(prod_ready), 64'sd0);
    for (int k = 0; k < hold; k++) begin
      prod_din = PW'(4095);
      prod_valid = 1'b1;
      @(posedge ap_clk); #1;
      check({tag, "_hold_valid"}, 64'(out_valid), 64'sd1);
      check({tag, "_hold_dout"}, 64'(out_dout), r);
      check({tag, "_hold_ready"}, 64'(prod_ready), 64'sd0);
    end
    prod_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 64'(out_valid), 64'sd0);
    check({tag, "_rel_ready"}, 64'(prod_ready), 64'sd1);
    check({tag, "_rel_busy"}, 64'(busy), 64'sd0);
    check({tag, "_hs"}, 64'(hs_count - hs0), 64'sd1);
  endtask

  initial begin
    longint q[$];
    logic signed [BW-1:0] rb;
    int hs0;

    // Reset state, observed while reset is held
    #3;
    check("rst_valid", 64'(out_valid), 64'sd0);
    check("rst_dout", 64'(out_dout), 64'sd0);
    check("rst_busy", 64'(busy), 64'sd0);
    check("rst_sat", 64'(sat_flag), 64'sd0);
    check("rst_ready", 64'(prod_ready), 64'sd1);
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    q = '{16, 32, 48, 64};
    run_window("basic", 0, q, 0, 0);

    q = '{4096, 4096, 4096, 4096};
    run_window("satur", 0, q, 0, 0);

    q = '{16, 16, 16, 16};
    run_window("negative", -320, q, 0, 0);

    q = '{100, 200, 300, 400};
    run_window("backpress", 0, q, 0, 5);
    q = '{16, 16, 16, 16};
    run_window("after_bp", 0, q, 0, 0);

    // Reset in the middle of a window
    bias = '0;
    send(16, 0);
    send(32, 0);
    check("mid_busy", 64'(busy), 64'sd1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'sd0);
    check("mrst_valid", 64'(out_valid), 64'sd0);
    check("mrst_dout", 64'(out_dout), 64'sd0);
    check("mrst_sat", 64'(sat_flag), 64'sd0);
    check("mrst_ready", 64'(prod_ready), 64'sd1);
    sat_model = 1'b0;
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    q = '{16, 16, 16, 16};
    run_window("post_rst", 0, q, 0, 0);

    // Gapped input: valid pattern 1,0,0,1,0,1,1
    hs0 = hs_count;
    bias = '0;
    send(16, 0);
    send(32, 2);
    send(48, 1);
    check("gap_no_early", 64'(out_valid), 64'sd0);
    send(64, 0);
    check("gap_valid", 64'(out_valid), 64'sd1);
    check("gap_dout", 64'(out_dout), 64'sd10);
    out_ready = 1'b1;
    repeat (3) begin @(posedge ap_clk); #1; end
    out_ready = 1'b0;
    check("gap_one_out", 64'(hs_count - hs0), 64'sd1);

    // Randomized windows against the reference model
    for (int w = 0; w < 30; w++) begin
      rb = BW'($urandom);
      q.delete();
      for (int t = 0; t < TAPS; t++) begin
        if (w % 3 == 0) q.push_back(longint'($urandom_range(0, (1 << PW) - 1)));
        else q.push_back(longint'($urandom_range(0, 1500)));
      end
      run_window("rand", longint'(rb), q, 2, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
